transmissor_estado_uart: RTL and testbench



---
 rtl/transmissor_estado_uart.sv | 156 +++++++++++++++
 tb/tb_transmissor_estado_uart.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_estado_uart.sv
// Serializes the game-status fields into a 4-byte packet (A5, {macro,micro},
// {estado,res_macro,res_jogo}, xor checksum) and sends it on an 8N1 UART line.
module transmissor_estado_uart #(
    parameter int CICLOS_POR_BIT = 434,
    parameter bit AUTO           = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [3:0] macro,
    input  logic [3:0] micro,
    input  logic [3:0] estado,
    input  logic [1:0] resultado_macro,
    input  logic [1:0] resultado_jogo,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pendente,
    output logic [2:0] db_estado_tx
);
    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] DADOS   = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] FIM     = 3'd5;

    localparam logic [15:0] ULTIMO_CICLO = 16'(CICLOS_POR_BIT - 1);
    localparam logic [7:0]  SINCRONISMO  = 8'hA5;

    logic [2:0]  estado_tx;
    logic [15:0] cont_ciclo;
    logic [2:0]  idx_bit;
    logic [1:0]  idx_byte;
    logic [15:0] campos_vivos;
    logic [15:0] instantaneo;
    logic [15:0] ultimo;
    logic        valido;
    logic        fim_bit;
    logic        em_linha;
    logic        pedido_auto;
    logic        pedido;
    logic [7:0]  byte_atual;

    // Field layout matches the packet: [15:8] is B1, [7:0] is B2.
    assign campos_vivos = {macro, micro, estado, resultado_macro, resultado_jogo};

    assign fim_bit  = (cont_ciclo == ULTIMO_CICLO);
    assign em_linha = (estado_tx == START) || (estado_tx == DADOS) || (estado_tx == STOP);

    // Request handshake: enviar has no ready; each high cycle is one request.
    // While idle a request starts a packet; during a packet the first request
    // sets pendente and any further ones are absorbed until it is consumed.
    // While a packet is on the line, AUTO compares against the packet's own
    // snapshot, which is exactly what FIM writes into the last-sent register.
    always_comb begin
        pedido_auto = 1'b0;
        case (estado_tx)
            OCIOSO:  pedido_auto = !valido || (campos_vivos != ultimo);
            CARREGA: pedido_auto = 1'b0;
            default: pedido_auto = (campos_vivos != instantaneo);
        endcase
    end

    assign pedido = enviar || (AUTO && pedido_auto);

    always_comb begin
        case (idx_byte)
            2'd0:    byte_atual = SINCRONISMO;
            2'd1:    byte_atual = instantaneo[15:8];
            2'd2:    byte_atual = instantaneo[7:0];
            default: byte_atual = SINCRONISMO ^ instantaneo[15:8] ^ instantaneo[7:0];
        endcase
    end

    always_comb begin
        case (estado_tx)
            START:   saida_serial = 1'b0;
            DADOS:   saida_serial = byte_atual[idx_bit];
            default: saida_serial = 1'b1;
        endcase
    end

    assign ocupado      = (estado_tx >= CARREGA) && (estado_tx <= FIM);
    assign db_estado_tx = estado_tx;

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_ciclo <= '0;
        end else if (em_linha && !fim_bit) begin
            cont_ciclo <= cont_ciclo + 16'd1;
        end else begin
            cont_ciclo <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_tx   <= OCIOSO;
            idx_bit     <= '0;
            idx_byte    <= '0;
            pendente    <= 1'b0;
            valido      <= 1'b0;
            instantaneo <= '0;
            ultimo      <= '0;
        end else begin
            if (estado_tx != OCIOSO && pedido) begin
                pendente <= 1'b1;
            end
            case (estado_tx)
                OCIOSO: begin
                    if (pedido || pendente) begin
                        pendente  <= 1'b0;
                        estado_tx <= CARREGA;
                    end
                end
                CARREGA: begin
                    instantaneo <= campos_vivos;
                    idx_byte    <= 2'd0;
                    idx_bit     <= 3'd0;
                    estado_tx   <= START;
                end
                START: begin
                    if (fim_bit) begin
                        idx_bit   <= 3'd0;
                        estado_tx <= DADOS;
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        if (idx_bit == 3'd7) begin
                            estado_tx <= STOP;
                        end else begin
                            idx_bit <= idx_bit + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (fim_bit) begin
                        if (idx_byte != 2'd3) begin
                            idx_byte  <= idx_byte + 2'd1;
                            estado_tx <= START;
                        end else begin
                            estado_tx <= FIM;
                        end
                    end
                end
                FIM: begin
                    ultimo    <= instantaneo;
                    valido    <= 1'b1;
                    estado_tx <= OCIOSO;
                end
                default: estado_tx <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_transmissor_estado_uart.sv
// Bench for transmissor_estado_uart: one manual instance (AUTO=0) and one
// auto instance (AUTO=1), both at 4 cycles per bit, with a UART line decoder.
module tb_transmissor_estado_uart;
    localparam int CPB = 4;

    typedef struct {
        logic [3:0] macro;
        logic [3:0] micro;
        logic [3:0] estado;
        logic [1:0] res_macro;
        logic [1:0] res_jogo;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
    } vec_t;

    logic       clock;
    logic       reset0, enviar0, tx0, ocup0, pend0;
    logic [3:0] macro0, micro0, estado0;
    logic [1:0] rm0, rj0;
    logic [2:0] db0;
    logic       reset1, enviar1, tx1, ocup1, pend1;
    logic [3:0] macro1, micro1, estado1;
    logic [1:0] rm1, rj1;
    logic [2:0] db1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx0_q[$];
    logic [7:0] rx1_q[$];
    vec_t vecs[5];

    transmissor_estado_uart #(.CICLOS_POR_BIT(CPB), .AUTO(1'b0)) dut_manual (
        .clock(clock), .reset(reset0), .enviar(enviar0),
        .macro(macro0), .micro(micro0), .estado(estado0),
        .resultado_macro(rm0), .resultado_jogo(rj0),
        .saida_serial(tx0), .ocupado(ocup0), .pendente(pend0), .db_estado_tx(db0)
    );

    transmissor_estado_uart #(.CICLOS_POR_BIT(CPB), .AUTO(1'b1)) dut_auto (
        .clock(clock), .reset(reset1), .enviar(enviar1),
        .macro(macro1), .micro(micro1), .estado(estado1),
        .resultado_macro(rm1), .resultado_jogo(rj1),
        .saida_serial(tx1), .ocupado(ocup1), .pendente(pend1), .db_estado_tx(db1)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic line_of(input int which);
        return (which == 0) ? tx0 : tx1;
    endfunction

    function automatic logic ocup_of(input int which);
        return (which == 0) ? ocup0 : ocup1;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // UART decoder: samples on negedges, mid-bit.
    task automatic uart_monitor(input int which);
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (line_of(which) == 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clock);
                    b[k] = line_of(which);
                end
                repeat (CPB) @(negedge clock);
                if (which == 0) rx0_q.push_back(b);
                else rx1_q.push_back(b);
            end
        end
    endtask

    initial uart_monitor(0);
    initial uart_monitor(1);

    // scoreboard
    task automatic push_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    task automatic check_rx(input int which, input string name);
        logic [7:0] e;
        logic [7:0] got;
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = 8'hxx;
            if (which == 0 && rx0_q.size() > 0) got = rx0_q.pop_front();
            if (which == 1 && rx1_q.size() > 0) got = rx1_q.pop_front();
            check($sformatf("%s byte%0d", name, idx), got, e);
            idx++;
        end
        check({name, " extra bytes"}, (which == 0) ? rx0_q.size() : rx1_q.size(), 0);
    endtask

    // drivers
    task automatic wait_ocup(input int which, input logic level, input int limit, input string name);
        int n;
        n = 0;
        while (ocup_of(which) !== level && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(name, ocup_of(which), level);
    endtask

    task automatic set_fields0(input vec_t v);
        macro0 = v.macro; micro0 = v.micro; estado0 = v.estado;
        rm0 = v.res_macro; rj0 = v.res_jogo;
    endtask

    task automatic send_vec(input vec_t v, input string name);
        int lat, occ;
        bit seen;
        set_fields0(v);
        enviar0 = 1'b1;
        lat = 0; occ = 0; seen = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (i == 1) enviar0 = 1'b0;
            if (!seen && tx0 == 1'b0) begin
                seen = 1'b1;
                lat = i;
            end
            if (ocup0) occ++;
            else if (occ > 0) break;
        end
        check({name, " start latency"}, lat, 2);
        check({name, " ocupado cycles"}, occ, 162);
        check({name, " pendente"}, pend0, 1'b0);
        push_packet(v.b1, v.b2, v.b3);
        check_rx(0, name);
    endtask

    initial begin
        int rises, gap, quiet, n;
        bit had_pkt;
        logic prev;

        vecs[0] = '{4'h3, 4'h7, 4'h5, 2'd2, 2'd1, 8'h37, 8'h59, 8'hCB};
        vecs[1] = '{4'hF, 4'hF, 4'hF, 2'd3, 2'd3, 8'hFF, 8'hFF, 8'hA5};
        vecs[2] = '{4'h0, 4'h0, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'hA5};
        vecs[3] = '{4'hA, 4'h5, 4'hC, 2'd1, 2'd2, 8'hA5, 8'hC6, 8'hC6};
        vecs[4] = '{4'h8, 4'h1, 4'h2, 2'd3, 2'd0, 8'h81, 8'h2C, 8'h08};

        reset0 = 1'b1; enviar0 = 1'b0; set_fields0(vecs[2]);
        reset1 = 1'b1; enviar1 = 1'b0;
        macro1 = '0; micro1 = '0; estado1 = '0; rm1 = '0; rj1 = '0;
        repeat (3) @(negedge clock);

        check("reset tx0", tx0, 1'b1);
        check("reset ocup0", ocup0, 1'b0);
        check("reset pend0", pend0, 1'b0);
        check("reset db0", db0, 3'd0);
        check("reset tx1", tx1, 1'b1);
        check("reset ocup1", ocup1, 1'b0);
        check("reset pend1", pend1, 1'b0);
        check("reset db1", db1, 3'd0);

        // AUTO: first packet after reset, then silence
        reset0 = 1'b0;
        reset1 = 1'b0;
        wait_ocup(1, 1'b1, 10, "auto first start");
        wait_ocup(1, 1'b0, 400, "auto first end");
        rises = 0;
        repeat (200) begin
            @(negedge clock);
            if (ocup1) rises++;
        end
        check("auto no resend busy cycles", rises, 0);
        push_packet(8'h00, 8'h00, 8'hA5);
        check_rx(1, "auto first");

        // AUTO: field changes mid-packet queue exactly one resend
        enviar1 = 1'b1;
        @(negedge clock);
        enviar1 = 1'b0;
        repeat (50) @(negedge clock);
        micro1 = 4'h4;
        @(negedge clock);
        check("auto change pendente", pend1, 1'b1);
        repeat (50) @(negedge clock);
        micro1 = 4'h6;
        wait_ocup(1, 1'b0, 300, "auto pkt a end");
        gap = 0;
        while (!ocup1 && gap < 10) begin
            gap++;
            @(negedge clock);
        end
        check("auto resend gap", gap, 1);
        wait_ocup(1, 1'b0, 300, "auto pkt b end");
        rises = 0;
        repeat (200) begin
            @(negedge clock);
            if (ocup1) rises++;
        end
        check("auto after resend busy cycles", rises, 0);
        push_packet(8'h00, 8'h00, 8'hA5);
        push_packet(8'h06, 8'h00, 8'hA3);
        check_rx(1, "auto change");

        // table-driven single packets on the manual instance
        for (int i = 0; i < 5; i++) begin
            send_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (5) @(negedge clock);
        end

        // five pulses during a packet queue one packet
        set_fields0(vecs[0]);
        enviar0 = 1'b1;
        @(negedge clock);
        enviar0 = 1'b0;
        for (int p = 0; p < 5; p++) begin
            repeat (15) @(negedge clock);
            enviar0 = 1'b1;
            @(negedge clock);
            enviar0 = 1'b0;
        end
        check("multi pulse pendente", pend0, 1'b1);
        rises = 0;
        prev = ocup0;
        repeat (600) begin
            @(negedge clock);
            if (ocup0 && !prev) rises++;
            prev = ocup0;
        end
        check("multi pulse extra packets", rises, 1);
        check("multi pulse idle ocup", ocup0, 1'b0);
        check("multi pulse idle pend", pend0, 1'b0);
        push_packet(8'h37, 8'h59, 8'hCB);
        push_packet(8'h37, 8'h59, 8'hCB);
        check_rx(0, "multi pulse");

        // enviar held high: back-to-back packets with a 1-cycle idle gap
        enviar0 = 1'b1;
        prev = ocup0;
        gap = 0;
        had_pkt = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clock);
            if (i == 500) enviar0 = 1'b0;
            if (!ocup0) gap++;
            if (ocup0 && !prev) begin
                if (had_pkt) check("hold gap", gap, 1);
                had_pkt = 1'b1;
                gap = 0;
            end
            prev = ocup0;
        end
        check("hold idle ocup", ocup0, 1'b0);
        check("hold idle pend", pend0, 1'b0);
        for (int p = 0; p < 5; p++) push_packet(8'h37, 8'h59, 8'hCB);
        check_rx(0, "hold");

        // reset during bit 3 of B1
        enviar0 = 1'b1;
        @(negedge clock);
        enviar0 = 1'b0;
        n = 0;
        while (tx0 !== 1'b0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("abort start seen", tx0, 1'b0);
        repeat (10) @(negedge clock);
        enviar0 = 1'b1;
        @(negedge clock);
        enviar0 = 1'b0;
        @(negedge clock);
        check("abort pendente set", pend0, 1'b1);
        repeat (45) @(negedge clock);
        check("abort in data state", db0, 3'd3);
        reset0 = 1'b1;
        @(negedge clock);
        check("abort tx idle", tx0, 1'b1);
        check("abort ocup", ocup0, 1'b0);
        check("abort pend", pend0, 1'b0);
        check("abort db", db0, 3'd0);
        reset0 = 1'b0;
        @(negedge clock);

        // enviar together with reset: reset wins
        reset0 = 1'b1;
        enviar0 = 1'b1;
        @(negedge clock);
        reset0 = 1'b0;
        enviar0 = 1'b0;
        check("reset wins ocup", ocup0, 1'b0);
        @(negedge clock);
        check("reset wins no start", ocup0, 1'b0);
        quiet = 0;
        repeat (200) begin
            @(negedge clock);
            if (ocup0 || !tx0) quiet++;
        end
        check("abort quiet line", quiet, 0);
        rx0_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
